// File: rtl/fetch_packet_queue_pkg.sv
// Shared frontend types for the fetch packet queue.
// Holds the fetch packet layout carried from the L1 I-cache response port to
// the decoder, its branch-prediction sub-struct, field-width constants and a
// helper that recognises packets with no valid instruction slots.
package fetch_packet_queue_pkg;

  localparam int unsigned FETCH_WIDTH = 4;
  localparam int unsigned XLEN        = 32;
  localparam int unsigned PKT_INDEX_W = 4;
  localparam int unsigned ROB_INDEX_W = 6;
  localparam int unsigned BR_TYPE_W   = 3;
  localparam int unsigned GHR_W       = 16;
  localparam int unsigned RAS_PTR_W   = 7;

  typedef struct packed {
    logic [XLEN-1:0]        instruction;
    logic [PKT_INDEX_W-1:0] packet_index;
    logic [ROB_INDEX_W-1:0] ROB_index;
  } instruction_t;

  typedef struct packed {
    logic                   hit;
    logic [XLEN-1:0]        target;
    logic [BR_TYPE_W-1:0]   br_type;
    logic [FETCH_WIDTH-1:0] br_mask;
  } prediction_t;

  typedef struct packed {
    logic [XLEN-1:0]                   fetch_PC;
    logic [FETCH_WIDTH-1:0]            valid_bits;
    instruction_t [FETCH_WIDTH-1:0]    instructions;
    prediction_t                       prediction;
    logic [GHR_W-1:0]                  GHR;
    logic [RAS_PTR_W-1:0]              NEXT;
    logic [RAS_PTR_W-1:0]              TOS;
  } fetch_packet_t;

  // A packet with no valid slot carries nothing for decode.
  function automatic logic pkt_is_empty(input fetch_packet_t p);
    return ~|p.valid_bits;
  endfunction

endpackage

// File: rtl/fetch_packet_queue_if.sv
// Handshake bundle between the I-cache response port, the fetch packet queue
// and the decoder.
//   io_in_valid / io_in_ready / io_in_bits    : cache -> queue
//   io_out_valid / io_out_ready / io_out_bits : queue -> decoder
// slave  : the queue side.
// master : the environment side (cache producer plus decoder consumer).
interface fetch_packet_queue_if;
  import fetch_packet_queue_pkg::*;

  logic          io_in_ready;
  logic          io_in_valid;
  fetch_packet_t io_in_bits;
  logic          io_out_ready;
  logic          io_out_valid;
  fetch_packet_t io_out_bits;

  modport slave (
    input  io_in_valid, io_in_bits, io_out_ready,
    output io_in_ready, io_out_valid, io_out_bits
  );

  modport master (
    output io_in_valid, io_in_bits, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_bits
  );

endinterface

// File: rtl/fetch_packet_queue_mem.sv
// Fetch packet storage: DEPTH entries of fetch_packet_t.
// One synchronous write port, one asynchronous read port. Not reset; the
// contents of unoccupied entries are never observed.
// Ports:
//   clock   : clock
//   we_i    : write enable
//   waddr_i : write entry index
//   wdata_i : packet to store
//   raddr_i : read entry index
//   rdata_o : packet at raddr_i (combinational)
module fetch_packet_queue_mem
  import fetch_packet_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  fetch_packet_t wdata_i,
  input  logic [AW-1:0] raddr_i,
  output fetch_packet_t rdata_o
);

  fetch_packet_t mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_packet_queue.sv
// Fetch packet queue: decoupling FIFO between the L1 I-cache response port and
// the decoder. Packets leave in accept order with fields unmodified. Packets
// whose valid_bits are all zero complete the handshake but are dropped. A kill
// (or reset) empties the queue at the end of the cycle it is asserted, and
// discards any handshake in that cycle.
// Ports:
//   clock    : clock
//   reset    : synchronous active-high reset
//   io_kill  : flush request from branch resolution / commit
//   io       : cache-side and decoder-side handshakes (slave modport)
//   io_count : current occupancy for the frontend stall logic
module fetch_packet_queue #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned FETCH_WIDTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_kill,
  fetch_packet_queue_if.slave      io,
  output logic [$clog2(DEPTH):0]   io_count
);
  import fetch_packet_queue_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fetch_packet_queue: DEPTH must be a power of two, at least 2");
  end
  if (FETCH_WIDTH != fetch_packet_queue_pkg::FETCH_WIDTH) begin : g_bad_width
    $error("fetch_packet_queue: FETCH_WIDTH must match the cache response format");
  end

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          enq, deq;

  // Status is derived only from registered count; there is no full bypass
  // and no empty bypass.
  assign io.io_in_ready  = (count_q != CW'(DEPTH));
  assign io.io_out_valid = (count_q != '0);
  assign io_count        = count_q;

  // Empty packets are acknowledged but never occupy an entry.
  assign enq = io.io_in_valid && io.io_in_ready && !io_kill
               && !pkt_is_empty(io.io_in_bits);
  assign deq = io.io_out_valid && io.io_out_ready && !io_kill;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CW'(enq) - CW'(deq);
    if (enq) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || io_kill) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  fetch_packet_queue_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clock   (clock),
    .we_i    (enq),
    .waddr_i (wr_ptr_q),
    .wdata_i (io.io_in_bits),
    .raddr_i (rd_ptr_q),
    .rdata_o (io.io_out_bits)
  );

endmodule

// File: tb/tb_fetch_packet_queue.sv
// Directed bench for fetch_packet_queue: a queue-based reference model is
// checked against the DUT on every cycle, and scenario-specific literal
// expectations pin the model.
module tb_fetch_packet_queue;
  import fetch_packet_queue_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       io_kill;
  logic [3:0] io_count;

  fetch_packet_queue_if bus ();

  fetch_packet_queue #(
    .DEPTH       (DEPTH),
    .FETCH_WIDTH (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .io_kill  (io_kill),
    .io       (bus),
    .io_count (io_count)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  fetch_packet_t model_q [$];

  task automatic check(input string name, input logic [299:0] act,
                       input logic [299:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic fetch_packet_t mk_pkt(input logic [31:0] pc,
                                           input logic [3:0] vb);
    fetch_packet_t p;
    p.fetch_PC   = pc;
    p.valid_bits = vb;
    for (int k = 0; k < 4; k++) begin
      p.instructions[k].instruction  = {pc[15:0], 16'(k)} ^ 32'hDEAD0000;
      p.instructions[k].packet_index = 4'(k);
      p.instructions[k].ROB_index    = pc[5:0] + 6'(k);
    end
    p.prediction.hit     = pc[4];
    p.prediction.target  = pc + 32'h40;
    p.prediction.br_type = pc[6:4];
    p.prediction.br_mask = pc[7:4];
    p.GHR  = pc[15:0] ^ 16'hA5A5;
    p.NEXT = pc[10:4];
    p.TOS  = pc[11:5];
    return p;
  endfunction

  // Reference model: a plain FIFO of accepted non-empty packets.
  always @(posedge clock) begin
    bit acc;
    bit pop;
    if (reset || io_kill) begin
      model_q.delete();
    end else begin
      acc = bus.io_in_valid && (model_q.size() < DEPTH);
      pop = bus.io_out_ready && (model_q.size() != 0);
      if (pop) void'(model_q.pop_front());
      if (acc && (bus.io_in_bits.valid_bits != 4'b0000))
        model_q.push_back(bus.io_in_bits);
    end
  end

  initial begin
    @(posedge clock);
    forever begin
      @(negedge clock);
      check("count", io_count, model_q.size());
      check("in_ready", bus.io_in_ready, model_q.size() < DEPTH);
      check("out_valid", bus.io_out_valid, model_q.size() != 0);
      if (model_q.size() != 0)
        check("out_bits", bus.io_out_bits, model_q[0]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset            = 1'b1;
    io_kill          = 1'b0;
    bus.io_in_valid  = 1'b0;
    bus.io_in_bits   = mk_pkt(32'h0, 4'h0);
    bus.io_out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    @(negedge clock);
    check("reset_count", io_count, 0);
    check("reset_in_ready", bus.io_in_ready, 1);
    check("reset_out_valid", bus.io_out_valid, 0);
    step();

    // Fill to full with the decoder stalled.
    for (int i = 0; i < 8; i++) begin
      bus.io_in_valid = 1'b1;
      bus.io_in_bits  = mk_pkt(32'h1000 + 32'(16 * i), 4'hF);
      step();
    end
    bus.io_in_bits = mk_pkt(32'h1080, 4'hF);
    @(negedge clock);
    check("fill_count", io_count, 8);
    check("fill_in_ready", bus.io_in_ready, 0);
    step();
    @(negedge clock);
    check("fill_held_count", io_count, 8);
    step();

    // Drain in order.
    bus.io_in_valid  = 1'b0;
    bus.io_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("drain_pc", bus.io_out_bits.fetch_PC, 32'h1000 + 32'(16 * i));
      check("drain_valid", bus.io_out_valid, 1);
      step();
    end
    @(negedge clock);
    check("drain_empty_valid", bus.io_out_valid, 0);
    check("drain_empty_count", io_count, 0);
    step();

    // Streaming across pointer wrap.
    for (int i = 0; i < 20; i++) begin
      bus.io_in_valid = 1'b1;
      bus.io_in_bits  = mk_pkt(32'h3000 + 32'(16 * i), 4'hF);
      @(negedge clock);
      if (i > 0) begin
        check("stream_pc", bus.io_out_bits.fetch_PC, 32'h3000 + 32'(16 * (i - 1)));
        check("stream_count", io_count, 1);
      end
      step();
    end
    bus.io_in_valid = 1'b0;
    @(negedge clock);
    check("stream_last_pc", bus.io_out_bits.fetch_PC, 32'h3130);
    step();
    @(negedge clock);
    check("stream_done_count", io_count, 0);
    step();

    // Kill with 5 entries while both handshakes are offered.
    bus.io_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.io_in_valid = 1'b1;
      bus.io_in_bits  = mk_pkt(32'h4000 + 32'(16 * i), 4'hF);
      step();
    end
    io_kill          = 1'b1;
    bus.io_in_bits   = mk_pkt(32'h4050, 4'hF);
    bus.io_out_ready = 1'b1;
    @(negedge clock);
    check("kill_cycle_count", io_count, 5);
    check("kill_cycle_out_valid", bus.io_out_valid, 1);
    check("kill_cycle_in_ready", bus.io_in_ready, 1);
    step();
    io_kill          = 1'b0;
    bus.io_in_bits   = mk_pkt(32'h2000, 4'hF);
    bus.io_out_ready = 1'b0;
    @(negedge clock);
    check("post_kill_count", io_count, 0);
    check("post_kill_out_valid", bus.io_out_valid, 0);
    step();
    bus.io_in_valid = 1'b0;
    @(negedge clock);
    check("post_kill_first_pc", bus.io_out_bits.fetch_PC, 32'h2000);
    check("post_kill_one", io_count, 1);
    bus.io_out_ready = 1'b1;
    step();
    bus.io_out_ready = 1'b0;

    // Empty packet is consumed without being stored.
    bus.io_in_valid = 1'b1;
    bus.io_in_bits  = mk_pkt(32'h5000, 4'b0000);
    @(negedge clock);
    check("empty_in_ready", bus.io_in_ready, 1);
    check("empty_pre_count", io_count, 0);
    step();
    bus.io_in_bits = mk_pkt(32'h5010, 4'b0011);
    @(negedge clock);
    check("empty_post_count", io_count, 0);
    step();
    bus.io_in_valid = 1'b0;
    @(negedge clock);
    check("partial_count", io_count, 1);
    check("partial_pc", bus.io_out_bits.fetch_PC, 32'h5010);
    check("partial_vb", bus.io_out_bits.valid_bits, 4'b0011);
    check("partial_rob0", bus.io_out_bits.instructions[0].ROB_index, 6'd16);
    check("partial_rob1", bus.io_out_bits.instructions[1].ROB_index, 6'd17);
    bus.io_out_ready = 1'b1;
    step();
    bus.io_out_ready = 1'b0;

    // Reset mid-stream with 3 entries buffered.
    for (int i = 0; i < 3; i++) begin
      bus.io_in_valid = 1'b1;
      bus.io_in_bits  = mk_pkt(32'h6000 + 32'(16 * i), 4'hF);
      step();
    end
    bus.io_in_valid = 1'b0;
    @(negedge clock);
    check("pre_reset_count", io_count, 3);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    check("mid_reset_count", io_count, 0);
    check("mid_reset_out_valid", bus.io_out_valid, 0);
    check("mid_reset_in_ready", bus.io_in_ready, 1);
    bus.io_in_valid = 1'b1;
    bus.io_in_bits  = mk_pkt(32'h7000, 4'h1);
    step();
    bus.io_in_valid = 1'b0;
    @(negedge clock);
    check("after_reset_pc", bus.io_out_bits.fetch_PC, 32'h7000);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_packet_queue.md
Name: fetch_packet_queue

Overview:
- Decoupling FIFO directly downstream of the L1 instruction cache.
- Accepts fetch packets (4-wide instruction bundle plus branch-prediction metadata) from the cache's CPU response port and buffers them.
- Presents packets in order to the decoder.
- On a pipeline kill it flushes every buffered packet so that no wrong-path instructions reach decode.

Parameters:
- DEPTH, 8, number of fetch-packet entries; must be a power of two, minimum 2.
- FETCH_WIDTH, 4, instructions per packet; fixed by the cache response format.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- io_kill  in  1  flush request, from branch resolution or commit.
- io_in_ready  out  1  queue can accept a packet; drives the cache's io_CPU_response_ready.
- io_in_valid  in  1  cache response valid.
- io_in_bits_fetch_PC  in  32  packet base PC.
- io_in_bits_valid_bits_N  in  1  per-slot valid, N=0..3.
- io_in_bits_instructions_N_instruction  in  32  instruction word, N=0..3.
- io_in_bits_instructions_N_packet_index  in  4  slot index, N=0..3.
- io_in_bits_instructions_N_ROB_index  in  6  ROB index, N=0..3.
- io_in_bits_prediction_hit  in  1  BTB hit.
- io_in_bits_prediction_target  in  32  predicted target.
- io_in_bits_prediction_br_type  in  3  branch type.
- io_in_bits_prediction_br_mask_N  in  1  branch mask, N=0..3.
- io_in_bits_GHR  in  16  global history.
- io_in_bits_NEXT  in  7  RAS next pointer.
- io_in_bits_TOS  in  7  RAS top-of-stack.
- io_out_ready  in  1  decoder accepts a packet.
- io_out_valid  out  1  head entry is valid.
- io_out_bits_*  out  (same widths as io_in_bits_*)  head packet, same field set as the input.
- io_count  out  $clog2(DEPTH)+1  occupancy, for the frontend stall logic.

Behaviour:
- Reset:
  - Read pointer, write pointer and count go to 0.
  - io_out_valid=0, io_count=0, io_in_ready=1.
  - Entry storage is not reset; io_out_bits is don't-care while io_out_valid=0.
- Status signals:
  - io_in_ready = (count != DEPTH). It is purely combinational from registered count; it never depends on io_out_ready (no full-bypass).
  - io_out_valid = (count != 0). io_out_bits = storage[rd_ptr], combinational read of registered state.
- Enqueue:
  - Occurs when io_in_valid && io_in_ready && !io_kill.
  - Packet is written at wr_ptr, and wr_ptr increments by 1.
  - Exception: if all four valid_bits are 0, the packet is consumed (handshake completes) but not stored; pointers and count are unchanged.
- Dequeue:
  - Occurs when io_out_valid && io_out_ready && !io_kill.
  - rd_ptr increments by 1.
- Pointer and count arithmetic:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally.
  - count is next-state = count + enq - deq.
- Simultaneous enqueue and dequeue with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Latency:
  - A packet enqueued in cycle t is visible on io_out in cycle t+1 at the earliest.
  - There is no same-cycle empty bypass.
- Full: io_in_ready=0. A dequeue in the same cycle raises io_in_ready in the next cycle only.
- Kill:
  - io_kill=1 in cycle t sets rd_ptr, wr_ptr and count to 0 at the edge ending cycle t.
  - Any enqueue or dequeue handshake in cycle t is discarded.
  - io_out_valid=0 in cycle t+1.
  - io_out_valid and io_in_ready keep their normal values during cycle t. The decoder must qualify with kill; the block itself performs no masking.
- Reset dominates kill. Reset asserted mid-stream drops all contents identically to kill.
- Ordering: output order equals accept order, and fields are passed through unmodified.

Decomposition:
- Shared frontend package holds:
  - fetch_packet_t struct (all io_*_bits fields).
  - prediction_t sub-struct.
  - FETCH_WIDTH, ROB_INDEX_W=6, GHR_W=16, RAS_PTR_W=7 constants.
- Natural sub-module: fetch_packet_queue_mem, a DEPTH x $bits(fetch_packet_t) register array with one write port and one async read port.
- Pointer, count and kill logic live in the top.

Test Plan:
- Fill: enqueue 8 packets with PC 0x1000,0x1010,…,0x1070, io_out_ready=0 -> io_count=8, io_in_ready=0 on the cycle after the 8th accept; 9th packet held by the cache.
- Drain order: from full, io_out_ready=1 for 8 cycles -> io_out_bits_fetch_PC sequence 0x1000…0x1070, and io_out_valid=0 afterwards.
- Wrap and streaming: 20 packets with both sides always ready -> one packet per cycle after a 1-cycle initial latency; io_count stays 1; PCs in order across pointer wrap.
- Kill:
  - With 5 entries, assert io_kill for 1 cycle together with io_in_valid=1 and io_out_ready=1 -> next cycle io_count=0 and io_out_valid=0.
  - The killed-cycle input is not stored, and the next enqueued PC 0x2000 is the first output.
- Empty packet: enqueue a packet with valid_bits=4'b0000 -> handshake completes and io_count is unchanged; a following packet with valid_bits=4'b0011 is stored and output with both ROB_index values intact.
- Reset mid-operation: assert reset with 3 entries buffered -> io_count=0, io_out_valid=0, io_in_ready=1 in the next cycle.
